// File: rtl/id_ex_pkg.sv
// Shared encodings for the ID/EX stage: ALUOp selects, ALU control codes and
// the funct field constants used by the ALU control decoder.
package id_ex_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_R   = 2'b10,
      OP_I   = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SLL = 4'b0100,
      ALU_SRL = 4'b0101,
      ALU_SUB = 4'b0110,
      ALU_SRA = 4'b0111,
      ALU_MUL = 4'b1111
   } alu_ctrl_e;

   // R-type keys are {funct7, funct3}
   localparam logic [9:0] F10_ADD = 10'b0000000_000;
   localparam logic [9:0] F10_SUB = 10'b0100000_000;
   localparam logic [9:0] F10_AND = 10'b0000000_111;
   localparam logic [9:0] F10_OR  = 10'b0000000_110;
   localparam logic [9:0] F10_XOR = 10'b0000000_100;
   localparam logic [9:0] F10_SLL = 10'b0000000_001;
   localparam logic [9:0] F10_SRL = 10'b0000000_101;
   localparam logic [9:0] F10_SRA = 10'b0100000_101;
   localparam logic [9:0] F10_MUL = 10'b0000001_000;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_ANDI = 3'b111;
   localparam logic [2:0] F3_ORI  = 3'b110;
   localparam logic [2:0] F3_XORI = 3'b100;
   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bus of the ID/EX stage; master is the decode/EX side,
// slave is the pipeline register itself.
interface id_ex_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RA_W  = 5,
   parameter int unsigned CNT_W = 16
);
   logic             id_valid_i;
   logic             id_ready_o;
   logic             flush_i;
   logic [XLEN-1:0]  rs1_data_i;
   logic [XLEN-1:0]  rs2_data_i;
   logic [XLEN-1:0]  iimm_i;
   logic [XLEN-1:0]  simm_i;
   logic [RA_W-1:0]  rs1_addr_i;
   logic [RA_W-1:0]  rs2_addr_i;
   logic [RA_W-1:0]  rd_addr_i;
   logic [2:0]       funct3_i;
   logic [6:0]       funct7_i;
   logic [1:0]       alu_op_i;
   logic             alu_src_i;
   logic [1:0]       mem_i;
   logic             wb_i;
   logic             ex_valid_o;
   logic             ex_ready_i;
   logic [XLEN-1:0]  val1_o;
   logic [XLEN-1:0]  val2_o;
   logic [XLEN-1:0]  simm_o;
   logic [RA_W-1:0]  rs1_addr_o;
   logic [RA_W-1:0]  rs2_addr_o;
   logic [RA_W-1:0]  rd_addr_o;
   logic [3:0]       alu_ctrl_o;
   logic [1:0]       mem_o;
   logic             wb_o;
   logic             illegal_o;
   logic [CNT_W-1:0] bubble_cnt_o;

   modport master (
      output id_valid_i, flush_i, rs1_data_i, rs2_data_i, iimm_i, simm_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_i,
             alu_op_i, alu_src_i, mem_i, wb_i, ex_ready_i,
      input  id_ready_o, ex_valid_o, val1_o, val2_o, simm_o, rs1_addr_o,
             rs2_addr_o, rd_addr_o, alu_ctrl_o, mem_o, wb_o, illegal_o,
             bubble_cnt_o
   );

   modport slave (
      input  id_valid_i, flush_i, rs1_data_i, rs2_data_i, iimm_i, simm_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_i,
             alu_op_i, alu_src_i, mem_i, wb_i, ex_ready_i,
      output id_ready_o, ex_valid_o, val1_o, val2_o, simm_o, rs1_addr_o,
             rs2_addr_o, rd_addr_o, alu_ctrl_o, mem_o, wb_o, illegal_o,
             bubble_cnt_o
   );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode from ALUOp and funct fields; anything not
// decodable falls back to ADD and raises illegal.
module alu_ctrl_dec
   import id_ex_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_ctrl,
   output logic       illegal
);
   alu_ctrl_e ctrl;

   always_comb begin
      ctrl    = ALU_ADD;
      illegal = 1'b0;
      case (alu_op_e'(alu_op))
         OP_ADD: ctrl = ALU_ADD;
         OP_SUB: ctrl = ALU_SUB;
         OP_R: begin
            case ({funct7, funct3})
               F10_ADD: ctrl = ALU_ADD;
               F10_SUB: ctrl = ALU_SUB;
               F10_AND: ctrl = ALU_AND;
               F10_OR:  ctrl = ALU_OR;
               F10_XOR: ctrl = ALU_XOR;
               F10_SLL: ctrl = ALU_SLL;
               F10_SRL: ctrl = ALU_SRL;
               F10_SRA: ctrl = ALU_SRA;
               F10_MUL: ctrl = ALU_MUL;
               default: illegal = 1'b1;
            endcase
         end
         default: begin
            // I-type: funct7 only qualifies the shift encodings
            case (funct3)
               F3_ADDI: ctrl = ALU_ADD;
               F3_ANDI: ctrl = ALU_AND;
               F3_ORI:  ctrl = ALU_OR;
               F3_XORI: ctrl = ALU_XOR;
               F3_SLLI: begin
                  if (funct7 == F7_BASE) ctrl = ALU_SLL;
                  else                   illegal = 1'b1;
               end
               F3_SRXI: begin
                  if (funct7 == F7_BASE)     ctrl = ALU_SRL;
                  else if (funct7 == F7_ALT) ctrl = ALU_SRA;
                  else                       illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
      endcase
   end

   assign alu_ctrl = ctrl;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, stall hold, flush
// bubble insertion, ALU control decode and a saturating bubble counter.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RA_W  = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   id_ex_stage_if.slave  bus
);
   logic [3:0] dec_ctrl;
   logic       dec_illegal;
   logic       load;

   alu_ctrl_dec u_alu_ctrl_dec (
      .alu_op   (bus.alu_op_i),
      .funct3   (bus.funct3_i),
      .funct7   (bus.funct7_i),
      .alu_ctrl (dec_ctrl),
      .illegal  (dec_illegal)
   );

   assign bus.id_ready_o = !bus.ex_valid_o || bus.ex_ready_i;
   assign load           = bus.id_valid_i && bus.id_ready_o && !bus.flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.ex_valid_o   <= 1'b0;
         bus.val1_o       <= '0;
         bus.val2_o       <= '0;
         bus.simm_o       <= '0;
         bus.rs1_addr_o   <= '0;
         bus.rs2_addr_o   <= '0;
         bus.rd_addr_o    <= '0;
         bus.alu_ctrl_o   <= '0;
         bus.mem_o        <= '0;
         bus.wb_o         <= 1'b0;
         bus.illegal_o    <= 1'b0;
         bus.bubble_cnt_o <= '0;
      end else begin
         if (!bus.ex_valid_o && bus.bubble_cnt_o != '1)
            bus.bubble_cnt_o <= bus.bubble_cnt_o + CNT_W'(1);

         // Side-effect controls are zeroed whenever the slot empties
         if (bus.flush_i || (!load && bus.ex_valid_o && bus.ex_ready_i)) begin
            bus.ex_valid_o <= 1'b0;
            bus.mem_o      <= '0;
            bus.wb_o       <= 1'b0;
            bus.illegal_o  <= 1'b0;
         end else if (load) begin
            bus.ex_valid_o <= 1'b1;
            bus.val1_o     <= bus.rs1_data_i;
            bus.val2_o     <= bus.alu_src_i ? bus.iimm_i : bus.rs2_data_i;
            bus.simm_o     <= bus.simm_i;
            bus.rs1_addr_o <= bus.rs1_addr_i;
            bus.rs2_addr_o <= bus.rs2_addr_i;
            bus.rd_addr_o  <= bus.rd_addr_i;
            bus.alu_ctrl_o <= dec_ctrl;
            bus.mem_o      <= bus.mem_i;
            bus.wb_o       <= bus.wb_i;
            bus.illegal_o  <= dec_illegal;
         end
      end
   end
endmodule
